// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline stage-control unit.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } pipe_st_e;

    // A stage "hits" a register when it writes it; $0 is hard-wired and never hits.
    function automatic logic stage_hit(input logic we, input logic [4:0] waddr,
                                       input logic [4:0] r);
        return we && (waddr == r) && (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register fields in, stage-control signals out.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_is_MUL;
    logic       exe_rf_we;
    logic [4:0] exe_rf_waddr;
    logic       exe_is_LW;
    logic       exe_is_MUL;
    logic       mem_rf_we;
    logic [4:0] mem_rf_waddr;
    logic       wb_rf_we;
    logic [4:0] wb_rf_waddr;

    logic       pc_we;
    logic       iireg_we;
    logic       iereg_we;
    logic       id_kill;
    logic       exe_kill;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       mdu_start;
    logic       mdu_busy;

    // Pipeline datapath side
    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_MUL,
               exe_rf_we, exe_rf_waddr, exe_is_LW, exe_is_MUL,
               mem_rf_we, mem_rf_waddr, wb_rf_we, wb_rf_waddr,
        input  pc_we, iireg_we, iereg_we, id_kill, exe_kill,
               fwd_a_sel, fwd_b_sel, mdu_start, mdu_busy
    );

    // Hazard controller side
    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_is_MUL,
               exe_rf_we, exe_rf_waddr, exe_is_LW, exe_is_MUL,
               mem_rf_we, mem_rf_waddr, wb_rf_we, wb_rf_waddr,
        output pc_we, iireg_we, iereg_we, id_kill, exe_kill,
               fwd_a_sel, fwd_b_sel, mdu_start, mdu_busy
    );
endinterface

// File: rtl/pipe_fwd_unit.sv
// Per-operand forwarding select: EXE > MEM > WB > regfile.
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] addr_i,
    input  logic       uses_i,
    input  logic       exe_we_i,
    input  logic [4:0] exe_waddr_i,
    input  logic       exe_fwd_ok_i,
    input  logic       mem_we_i,
    input  logic [4:0] mem_waddr_i,
    input  logic       wb_we_i,
    input  logic [4:0] wb_waddr_i,
    output logic [1:0] sel_o
);

    // LW/MUL results are not ready in EXE, so those fall through to older stages.
    always_comb begin
        sel_o = FWD_RF;
        if (uses_i) begin
            if (exe_fwd_ok_i && stage_hit(exe_we_i, exe_waddr_i, addr_i)) sel_o = FWD_EXE;
            else if (stage_hit(mem_we_i, mem_waddr_i, addr_i))           sel_o = FWD_MEM;
            else if (stage_hit(wb_we_i, wb_waddr_i, addr_i))             sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage-control unit: stalls, bubbles, forwarding and the multi-cycle MUL freeze.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal flow; load/MUL-use bubble and MUL issue detected
//   ST_BUSY | MUL occupying EXE; front end frozen, EXE/MEM input killed
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   hz_if
);

    pipe_st_e   st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       start_q, start_d;

    logic       exe_fwd_ok;
    logic       dep_exe;
    logic       load_use;
    logic       issue;
    logic [1:0] fwd_a, fwd_b;

    assign exe_fwd_ok = !hz_if.exe_is_LW && !hz_if.exe_is_MUL;

    pipe_fwd_unit u_fwd_a (
        .addr_i      (hz_if.id_rs_addr),
        .uses_i      (hz_if.id_uses_rs),
        .exe_we_i    (hz_if.exe_rf_we),
        .exe_waddr_i (hz_if.exe_rf_waddr),
        .exe_fwd_ok_i(exe_fwd_ok),
        .mem_we_i    (hz_if.mem_rf_we),
        .mem_waddr_i (hz_if.mem_rf_waddr),
        .wb_we_i     (hz_if.wb_rf_we),
        .wb_waddr_i  (hz_if.wb_rf_waddr),
        .sel_o       (fwd_a)
    );

    pipe_fwd_unit u_fwd_b (
        .addr_i      (hz_if.id_rt_addr),
        .uses_i      (hz_if.id_uses_rt),
        .exe_we_i    (hz_if.exe_rf_we),
        .exe_waddr_i (hz_if.exe_rf_waddr),
        .exe_fwd_ok_i(exe_fwd_ok),
        .mem_we_i    (hz_if.mem_rf_we),
        .mem_waddr_i (hz_if.mem_rf_waddr),
        .wb_we_i     (hz_if.wb_rf_we),
        .wb_waddr_i  (hz_if.wb_rf_waddr),
        .sel_o       (fwd_b)
    );

    // Hazard detection; a MUL is issued only when it actually moves into EXE.
    always_comb begin
        dep_exe  = (hz_if.id_uses_rs && stage_hit(hz_if.exe_rf_we, hz_if.exe_rf_waddr, hz_if.id_rs_addr))
                || (hz_if.id_uses_rt && stage_hit(hz_if.exe_rf_we, hz_if.exe_rf_waddr, hz_if.id_rt_addr));
        load_use = (st_q == ST_RUN) && dep_exe && (hz_if.exe_is_LW || hz_if.exe_is_MUL);
        issue    = (st_q == ST_RUN) && !load_use && hz_if.id_is_MUL;
    end

    // Next-state: BUSY holds for MUL_CYCLES-1 cycles; the MUL's last EXE cycle is in RUN.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        start_d = issue;
        case (st_q)
            ST_RUN: begin
                if (issue && (MUL_CYCLES > 1)) begin
                    st_d  = ST_BUSY;
                    cnt_d = 4'(MUL_CYCLES - 1);
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd1) begin
                    st_d  = ST_RUN;
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                st_d  = ST_RUN;
                cnt_d = 4'd0;
            end
        endcase
    end

    // State registers; reset abandons any MUL in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= ST_RUN;
            cnt_q   <= 4'd0;
            start_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    // Control outputs; BUSY overrides the bubble, reset overrides everything.
    always_comb begin
        hz_if.pc_we     = 1'b1;
        hz_if.iireg_we  = 1'b1;
        hz_if.iereg_we  = 1'b1;
        hz_if.id_kill   = 1'b0;
        hz_if.exe_kill  = 1'b0;
        hz_if.fwd_a_sel = FWD_RF;
        hz_if.fwd_b_sel = FWD_RF;
        hz_if.mdu_start = 1'b0;
        hz_if.mdu_busy  = 1'b0;
        if (!reset) begin
            hz_if.fwd_a_sel = fwd_a;
            hz_if.fwd_b_sel = fwd_b;
            hz_if.mdu_start = start_q;
            if (st_q == ST_BUSY) begin
                hz_if.pc_we    = 1'b0;
                hz_if.iireg_we = 1'b0;
                hz_if.iereg_we = 1'b0;
                hz_if.exe_kill = 1'b1;
                hz_if.mdu_busy = 1'b1;
            end else if (load_use) begin
                hz_if.pc_we    = 1'b0;
                hz_if.iireg_we = 1'b0;
                hz_if.id_kill  = 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Stage-control unit for the 5-stage pipeline. It reads destination and type fields from the EXE, MEM and WB pipeline registers, and the source fields of the instruction in ID. It drives the write enables of the PC and of the IF/ID and ID/EXE registers, the bubble kills, and the operand-forwarding selects. It owns a counter FSM that freezes the front end while a multi-cycle MUL occupies EXE.

Parameters:
MUL_CYCLES, 4, cycles a MUL spends in EXE (legal range 1..15).

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
id_rs_addr  in  5  rs field of the ID instruction
id_rt_addr  in  5  rt field of the ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_MUL  in  1  ID instruction is MUL
exe_rf_we  in  1  EXE-stage register write enable
exe_rf_waddr  in  5  EXE-stage destination register
exe_is_LW  in  1  EXE-stage instruction is LW
exe_is_MUL  in  1  EXE-stage instruction is MUL
mem_rf_we  in  1  MEM-stage register write enable
mem_rf_waddr  in  5  MEM-stage destination register
wb_rf_we  in  1  WB-stage register write enable
wb_rf_waddr  in  5  WB-stage destination register
pc_we  out  1  PC update enable
iireg_we  out  1  IF/ID register write enable
iereg_we  out  1  ID/EXE register write enable
id_kill  out  1  forces id_rf_we and id_dmem_we to 0 at the ID/EXE input (inserts a bubble)
exe_kill  out  1  forces exe_rf_we and exe_dmem_we to 0 at the EXE/MEM input
fwd_a_sel  out  2  rs operand source: 0 regfile, 1 EXE result, 2 MEM result, 3 WB result
fwd_b_sel  out  2  rt operand source, same encoding as fwd_a_sel
mdu_start  out  1  one-cycle pulse on the first EXE cycle of a MUL
mdu_busy  out  1  high while the FSM is in BUSY

Behaviour:
- State: st in {RUN, BUSY}, plus a 4-bit counter cnt.
- Reset (synchronous):
  - st=RUN, cnt=0.
  - While reset is high, outputs are forced to: pc_we=1, iireg_we=1, iereg_we=1, id_kill=0, exe_kill=0, fwd_*=0, mdu_start=0, mdu_busy=0.
  - Reset during BUSY abandons the MUL; no further stall is asserted.
- Match definitions (register 0 never matches):
  - hitX(r) = X_rf_we && X_rf_waddr==r && r!=0, for stage X in {exe, mem, wb}.
  - depX = (id_uses_rs && hitX(id_rs_addr)) || (id_uses_rt && hitX(id_rt_addr)).
- Forwarding is combinational and evaluated in every state. For each operand, priority is EXE > MEM > WB > regfile, giving codes 1/2/3/0. The EXE code is only chosen when the EXE instruction is neither LW nor MUL; otherwise the operand falls through to the next priority.
- RUN:
  - Load/MUL-use hazard: depexe && (exe_is_LW || exe_is_MUL). Response: pc_we=0, iireg_we=0, iereg_we=1, id_kill=1. This is a one-cycle bubble; next cycle the producer is in MEM and forwards with code 2.
  - Otherwise all enables are 1 and both kills are 0.
  - MUL issue: id_is_MUL && iereg_we && !id_kill. If MUL_CYCLES>1, next cycle st=BUSY, cnt=MUL_CYCLES-1, and mdu_start=1 in that first BUSY cycle. If MUL_CYCLES==1, the FSM stays in RUN and mdu_start still pulses on the first EXE cycle.
- BUSY:
  - Outputs: pc_we=0, iireg_we=0, iereg_we=0, id_kill=0, exe_kill=1, mdu_busy=1.
  - cnt decrements each cycle. When cnt==1, next st=RUN and cnt=0.
  - The first RUN cycle is the MUL's last EXE cycle. exe_kill=0 in that cycle so the result enters EXE/MEM exactly once. Normal RUN rules apply, including a MUL-use bubble.
  - Total cycles a MUL spends in EXE = MUL_CYCLES; front-end stall = MUL_CYCLES-1 cycles.
  - Load-use detection is suppressed while in BUSY.
- Simultaneous events:
  - BUSY overrides every RUN rule.
  - A load-use bubble with a MUL in ID: the MUL is not issued, because id_kill=1.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF=2'd0, FWD_EXE=2'd1, FWD_MEM=2'd2, FWD_WB=2'd3;
  - ST_RUN/ST_BUSY encodings;
  - REG_ZERO=5'd0.
- One natural sub-module: pipe_fwd_unit. It is combinational, instanced once per operand, and maps (addr, uses, stage fields) to a 2-bit select.

Test Plan:
- LW $2 in EXE, ID uses rs=$2 -> one cycle with pc_we=0, iireg_we=0, id_kill=1; next cycle fwd_a_sel=2, all enables 1.
- ADD writing $3 in EXE, SUB writing $3 in MEM, ID reads rt=$3 -> fwd_b_sel=1, no stall.
- Only WB writes $5 and ID reads rs=$5 -> fwd_a_sel=3. Same case with waddr=0 -> fwd_a_sel=0, no stall.
- MUL issued with MUL_CYCLES=4 -> mdu_start pulse, then 3 cycles of mdu_busy=1, exe_kill=1, iereg_we=0; 4th cycle in RUN with exe_kill=0.
- MUL followed by a dependent ADD -> after BUSY ends, exactly one bubble, then fwd code 2.
- Reset asserted on the 2nd BUSY cycle -> next cycle st=RUN, mdu_busy=0, all enables 1.
